// File: rtl/i2c_pkg.sv
// Shared types for the I2C command queue: FSM state encoding, command layout and a
// small elaboration-time helper.
package i2c_pkg;

  localparam int CMD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
  } cmd_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/i2c_cmd_queue_if.sv
// Host push port plus master send/busy handshake; slave is the queue's view, master the driver's.
interface i2c_cmd_queue_if #(
  parameter int DEPTH = 8
);
  logic                     wr_en;
  logic                     wr_rw;
  logic [6:0]               wr_addr;
  logic [7:0]               wr_data;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     m_send;
  logic                     m_busy;
  logic                     m_rw;
  logic [6:0]               m_addr;
  logic [7:0]               m_data;
  logic                     idle;
  logic                     err_tmo;

  modport slave (
    input  wr_en, wr_rw, wr_addr, wr_data, m_busy,
    output full, empty, count, m_send, m_rw, m_addr, m_data, idle, err_tmo
  );

  modport master (
    output wr_en, wr_rw, wr_addr, wr_data, m_busy,
    input  full, empty, count, m_send, m_rw, m_addr, m_data, idle, err_tmo
  );
endinterface

// File: rtl/i2c_cmd_fifo.sv
// Synchronous FIFO, DEPTH x W, head visible combinationally; push while full is dropped
// unless a pop happens in the same cycle, in which case both act.
module i2c_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_dat = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/i2c_cmd_queue.sv
// Buffers host I2C commands and dispatches them one at a time over send/busy; m_send rises
// on the 2nd clk after a push into an idle queue, commands are held while the master is busy.
module i2c_cmd_queue
  import i2c_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int GAP_CYC = 1000,
  parameter int TMO_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  i2c_cmd_queue_if.slave     bus
);
  localparam int TMR_W = $clog2(imax(GAP_CYC, TMO_CYC)) + 1;
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TMO_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYC - 1);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             m_send_q, m_send_d;
  logic             err_tmo_q, err_tmo_d;
  cmd_t             cmd_q, cmd_d;

  logic             pop;
  logic             empty;
  logic [CMD_W-1:0] head_dat;
  cmd_t             head;

  i2c_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.wr_en),
    .push_dat ({bus.wr_rw, bus.wr_addr, bus.wr_data}),
    .pop      (pop),
    .pop_dat  (head_dat),
    .full     (bus.full),
    .empty    (empty),
    .count    (bus.count)
  );

  assign head      = cmd_t'(head_dat);
  assign bus.empty   = empty;
  assign bus.m_send  = m_send_q;
  assign bus.m_rw    = cmd_q.rw;
  assign bus.m_addr  = cmd_q.addr;
  assign bus.m_data  = cmd_q.data;
  assign bus.err_tmo = err_tmo_q;
  assign bus.idle    = (state_q == ST_IDLE) && empty;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    m_send_d  = m_send_q;
    err_tmo_d = err_tmo_q;
    cmd_d     = cmd_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty && !bus.m_busy) begin
          pop      = 1'b1;
          cmd_d    = head;
          m_send_d = 1'b1;
          timer_d  = '0;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        // A busy seen on the last timer cycle still counts as a start, not a timeout.
        if (bus.m_busy) begin
          m_send_d = 1'b0;
          timer_d  = '0;
          state_d  = ST_XFER;
        end else if (timer_q == TMO_LAST) begin
          m_send_d  = 1'b0;
          err_tmo_d = 1'b1;
          timer_d   = '0;
          state_d   = ST_GAP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_XFER: begin
        if (!bus.m_busy) begin
          timer_d = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        timer_d  = '0;
        m_send_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      m_send_q  <= 1'b0;
      err_tmo_q <= 1'b0;
      cmd_q     <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      m_send_q  <= m_send_d;
      err_tmo_q <= err_tmo_d;
      cmd_q     <= cmd_d;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Directed bench for i2c_cmd_queue with short gap/timeout so every boundary is reachable quickly.
module tb_i2c_cmd_queue;
  localparam int DEPTH  = 4;
  localparam int GAP    = 10;
  localparam int TMO    = 20;
  localparam int BUDGET = GAP + TMO + 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_cmd_queue_if #(.DEPTH(DEPTH)) bus ();

  i2c_cmd_queue #(.DEPTH(DEPTH), .GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int npass = 0;
  int nchk  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_wr(input logic rw, input logic [6:0] a, input logic [7:0] d);
    bus.wr_rw   = rw;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  task automatic push(input logic rw, input logic [6:0] a, input logic [7:0] d);
    set_wr(rw, a, d);
    bus.wr_en = 1'b1;
    tick(1);
    bus.wr_en = 1'b0;
  endtask

  function automatic logic [31:0] cur_cmd();
    return 32'({bus.m_rw, bus.m_addr, bus.m_data});
  endfunction

  task automatic wait_send(input string tag, output int cyc);
    cyc = 0;
    while (bus.m_send !== 1'b1 && cyc < BUDGET) begin
      tick(1);
      cyc++;
    end
    chk({tag, "_send_seen"}, 32'(bus.m_send), 32'd1);
  endtask

  // Plays the master: sees send, raises busy for 3 cycles, drops it.
  task automatic do_xfer(input string tag, input logic rw, input logic [6:0] a,
                         input logic [7:0] d, output int cyc);
    wait_send(tag, cyc);
    chk({tag, "_cmd"}, cur_cmd(), 32'({rw, a, d}));
    bus.m_busy = 1'b1;
    tick(1);
    chk({tag, "_send_drop"}, 32'(bus.m_send), 32'd0);
    tick(2);
    chk({tag, "_hold"}, cur_cmd(), 32'({rw, a, d}));
    bus.m_busy = 1'b0;
  endtask

  logic [15:0] b2b [3];
  int          cyc;

  initial begin
    bus.wr_en  = 1'b0;
    bus.m_busy = 1'b0;
    set_wr(1'b0, 7'h00, 8'h00);
    rst = 1'b1;
    tick(2);

    chk("rst_count",  32'(bus.count),   32'd0);
    chk("rst_empty",  32'(bus.empty),   32'd1);
    chk("rst_full",   32'(bus.full),    32'd0);
    chk("rst_send",   32'(bus.m_send),  32'd0);
    chk("rst_cmd",    cur_cmd(),        32'd0);
    chk("rst_idle",   32'(bus.idle),    32'd1);
    chk("rst_err",    32'(bus.err_tmo), 32'd0);
    rst = 1'b0;
    tick(1);

    // Single command: latency and gap length
    push(1'b0, 7'h1A, 8'hA5);
    chk("lat1_send",  32'(bus.m_send), 32'd0);
    chk("lat1_count", 32'(bus.count),  32'd1);
    tick(1);
    chk("lat2_send",  32'(bus.m_send), 32'd1);
    chk("lat2_cmd",   cur_cmd(),       32'h1AA5);
    chk("lat2_count", 32'(bus.count),  32'd0);
    chk("lat2_idle",  32'(bus.idle),   32'd0);
    bus.m_busy = 1'b1;
    tick(1);
    chk("single_send_drop", 32'(bus.m_send), 32'd0);
    tick(2);
    bus.m_busy = 1'b0;
    tick(1);
    tick(GAP - 1);
    chk("gap_not_idle", 32'(bus.idle), 32'd0);
    chk("gap_cmd_hold", cur_cmd(),     32'h1AA5);
    tick(1);
    chk("gap_idle",     32'(bus.idle), 32'd1);

    // Three back-to-back pushes, dispatched in order with full gap spacing
    b2b[0] = {1'b1, 7'h10, 8'h01};
    b2b[1] = {1'b0, 7'h22, 8'h02};
    b2b[2] = {1'b1, 7'h7F, 8'hFF};
    bus.wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_wr(b2b[i][15], b2b[i][14:8], b2b[i][7:0]);
      tick(1);
    end
    bus.wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_xfer("b2b", b2b[i][15], b2b[i][14:8], b2b[i][7:0], cyc);
      if (i > 0) chk("b2b_gap_cycles", 32'(cyc), 32'(GAP + 2));
    end
    tick(GAP + 1);
    chk("b2b_idle", 32'(bus.idle), 32'd1);

    // Overfill with master stalled: last push dropped
    bus.m_busy = 1'b1;
    bus.wr_en  = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      set_wr(1'(i), 7'(7'h40 + i), 8'(8'hC0 + i));
      tick(1);
    end
    bus.wr_en = 1'b0;
    chk("ovf_full",  32'(bus.full),  32'd1);
    chk("ovf_count", 32'(bus.count), 32'(DEPTH));
    tick(3);
    chk("stall_no_pop",  32'(bus.count),  32'(DEPTH));
    chk("stall_no_send", 32'(bus.m_send), 32'd0);
    bus.m_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      do_xfer("ovf", 1'(i), 7'(7'h40 + i), 8'(8'hC0 + i), cyc);
    end
    tick(GAP + 2);
    chk("ovf_dropped_idle", 32'(bus.idle),   32'd1);
    chk("ovf_dropped_send", 32'(bus.m_send), 32'd0);

    // Master never starts: timeout, then next command still goes out
    push(1'b1, 7'h55, 8'h5A);
    push(1'b0, 7'h33, 8'hC3);
    wait_send("tmo", cyc);
    chk("tmo_cmd", cur_cmd(), 32'hD55A);
    tick(TMO - 1);
    chk("tmo_pre_send", 32'(bus.m_send),  32'd1);
    chk("tmo_pre_err",  32'(bus.err_tmo), 32'd0);
    tick(1);
    chk("tmo_send", 32'(bus.m_send),  32'd0);
    chk("tmo_err",  32'(bus.err_tmo), 32'd1);
    do_xfer("tmo_next", 1'b0, 7'h33, 8'hC3, cyc);
    chk("tmo_err_sticky", 32'(bus.err_tmo), 32'd1);
    tick(GAP + 1);
    chk("tmo_idle", 32'(bus.idle), 32'd1);

    // Push and pop in the same cycle while full
    bus.m_busy = 1'b1;
    bus.wr_en  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_wr(1'b0, 7'(7'h60 + i), 8'(8'h90 + i));
      tick(1);
    end
    chk("pp_full", 32'(bus.full), 32'd1);
    set_wr(1'b1, 7'h6F, 8'h9F);
    bus.m_busy = 1'b0;
    tick(1);
    bus.wr_en = 1'b0;
    chk("pp_count", 32'(bus.count),  32'(DEPTH));
    chk("pp_send",  32'(bus.m_send), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      do_xfer("pp", 1'b0, 7'(7'h60 + i), 8'(8'h90 + i), cyc);
    end
    do_xfer("pp_last", 1'b1, 7'h6F, 8'h9F, cyc);
    tick(GAP + 1);
    chk("pp_idle", 32'(bus.idle), 32'd1);

    // Reset asserted mid-transfer
    push(1'b0, 7'h11, 8'h22);
    wait_send("rx", cyc);
    bus.m_busy = 1'b1;
    tick(1);
    push(1'b1, 7'h01, 8'h02);
    push(1'b1, 7'h03, 8'h04);
    chk("rx_count_pre", 32'(bus.count), 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("rx_send",  32'(bus.m_send),  32'd0);
    chk("rx_count", 32'(bus.count),   32'd0);
    chk("rx_idle",  32'(bus.idle),    32'd1);
    chk("rx_err",   32'(bus.err_tmo), 32'd0);
    chk("rx_cmd",   cur_cmd(),        32'd0);
    bus.m_busy = 1'b0;
    tick(1);
    rst = 1'b0;
    push(1'b1, 7'h2B, 8'h3C);
    chk("post_rst_lat1", 32'(bus.m_send), 32'd0);
    tick(1);
    chk("post_rst_send", 32'(bus.m_send), 32'd1);
    chk("post_rst_cmd",  cur_cmd(),       32'hAB3C);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
